// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one big-endian memory port between fetch (I) and
//            load/store (D) requesters, with LATENCY wait states per access.
//            Define MEM_ARB_RR_EN for round-robin arbitration on contention.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_owner_d;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [31:0]        r_irdata;
    logic [63:0]        r_drdata;
    logic               w_grant_d;
    logic               w_start;
    logic               w_fire;

    assign w_start = (r_state == S_IDLE) && (i_req || d_req);

`ifdef MEM_ARB_RR_EN
    // Last owner starts as I so that D takes the first contention.
    logic r_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_d <= 1'b0;
        else if (w_start)
            r_last_d <= w_grant_d;
    end

    always_comb begin
        w_grant_d = d_req && (!i_req || !r_last_d);
    end
`else
    always_comb begin
        w_grant_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        m_we        = 1'b0;
        m_addr      = 32'd0;
        m_wdata     = 64'd0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req)
                    w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                m_addr  = r_addr;
                m_wdata = r_wdata;
                if (r_cnt == '0) begin
                    w_fire      = 1'b1;
                    m_we        = r_we;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                i_ready     = !r_owner_d;
                d_ready     = r_owner_d;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Access parameters are latched at grant so requester changes mid-access are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 64'd0;
            r_irdata  <= 32'd0;
            r_drdata  <= 64'd0;
        end else begin
            if (w_start) begin
                r_owner_d <= w_grant_d;
                r_we      <= w_grant_d && d_we;
                r_addr    <= w_grant_d ? d_addr : i_addr;
                r_wdata   <= w_grant_d ? d_wdata : 64'd0;
                r_cnt     <= CNT_W'(LATENCY);
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_fire) begin
                if (r_owner_d)
                    r_drdata <= m_rdata;
                else
                    r_irdata <= m_rdata[63:32];
            end
        end
    end

    assign i_rdata = r_irdata;
    assign d_rdata = r_drdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (LATENCY=2 and LATENCY=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic        i_ready, d_ready, m_we;
    logic [31:0] i_rdata, m_addr;
    logic [63:0] d_rdata, m_wdata, m_rdata;

    logic        z_i_req, z_d_req, z_d_we;
    logic [31:0] z_i_addr, z_d_addr;
    logic [63:0] z_d_wdata;
    logic        z_i_ready, z_d_ready, z_m_we;
    logic [31:0] z_i_rdata, z_m_addr;
    logic [63:0] z_d_rdata, z_m_wdata, z_m_rdata;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_we = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_arbiter #(.LATENCY(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_ready(z_i_ready), .i_rdata(z_i_rdata),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_ready(z_d_ready), .d_rdata(z_d_rdata),
        .m_we(z_m_we), .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_rdata(z_m_rdata)
    );

    // 256-byte big-endian memory with address wrap; the LATENCY=0 instance sees a fixed pattern.
    always_comb begin
        for (int k = 0; k < 8; k++)
            m_rdata[63-8*k -: 8] = mem[8'(m_addr[7:0] + k)];
    end

    always_comb begin
        for (int k = 0; k < 8; k++)
            z_m_rdata[63-8*k -: 8] = 8'(z_m_addr[7:0] + k + 1);
    end

    always @(posedge clk) begin
        if (m_we)
            for (int k = 0; k < 8; k++)
                mem[8'(m_addr[7:0] + k)] <= m_wdata[63-8*k -: 8];
    end

    always @(negedge clk) begin
        if (m_we)
            n_we++;
    end

    function automatic logic [63:0] ref_rd(input logic [7:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            r[63-8*k -: 8] = ref_mem[8'(a + k)];
        return r;
    endfunction

    task automatic ref_wr(input logic [7:0] a, input logic [63:0] d);
        for (int k = 0; k < 8; k++)
            ref_mem[8'(a + k)] = d[63-8*k -: 8];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Runs one access starting in an IDLE cycle; scrambles requester inputs after grant.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [63:0] exp, input string name);
        int k;
        int we0;
        we0 = n_we;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                d_we = ~we; d_addr = $urandom; d_wdata = {$urandom, $urandom}; i_addr = $urandom;
            end
            if (i_ready || d_ready) break;
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk({name, " latency"}, 64'(k), 64'(LAT + 2));
        chk({name, " owner"}, {62'd0, i_ready, d_ready}, is_d ? 64'd1 : 64'd2);
        if (is_d)
            chk({name, " rdata"}, d_rdata, exp);
        else
            chk({name, " rdata"}, {32'd0, i_rdata}, exp);
        chk({name, " we pulses"}, 64'(n_we - we0), (is_d && we) ? 64'd1 : 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          k, k1, got;
        bit          own [4];
        bit          exp_own [4];
        logic [63:0] e;
        logic [63:0] rw;

        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        z_i_req = 0; z_d_req = 0; z_d_we = 0; z_i_addr = 0; z_d_addr = 0; z_d_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i + 1);
            ref_mem[i] = 8'(i + 1);
        end

        tbl[0] = '{0, 0, 32'd0,   64'd0,                 64'h0000_0000_0102_0304};
        tbl[1] = '{1, 1, 32'd8,   64'h1122334455667788,  64'h090A_0B0C_0D0E_0F10};
        tbl[2] = '{1, 0, 32'd8,   64'd0,                 64'h1122_3344_5566_7788};
        tbl[3] = '{0, 0, 32'd12,  64'd0,                 64'h0000_0000_5566_7788};
        tbl[4] = '{1, 0, 32'd0,   64'd0,                 64'h0102_0304_0506_0708};
        tbl[5] = '{1, 0, 32'd252, 64'd0,                 64'hFDFE_FF00_0102_0304};

        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", {61'd0, m_we, i_ready, d_ready}, 64'd0);
        chk("reset m_addr", {32'd0, m_addr}, 64'd0);
        chk("reset rdata", d_rdata | {32'd0, i_rdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            access(tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("vec%0d", i));
            if (tbl[i].we)
                ref_wr(tbl[i].addr[7:0], tbl[i].wd);
        end

        for (int i = 0; i < 40; i++) begin
            bit          rd_d, rd_we;
            logic [31:0] ra;
            logic [63:0] rwd;
            rd_d = 1'($urandom);
            rd_we = rd_d && 1'($urandom);
            ra = $urandom;
            rwd = {$urandom, $urandom};
            rw = ref_rd(ra[7:0]);
            e = rd_d ? rw : {32'd0, rw[63:32]};
            access(rd_d, rd_we, ra, rwd, e, $sformatf("rnd%0d", i));
            if (rd_we)
                ref_wr(ra[7:0], rwd);
        end

        // Held load request: a single IDLE bubble separates the two completions.
        d_req = 1; d_we = 0; d_addr = 32'h30;
        k = 0; k1 = 0; got = 0;
        while (got < 2 && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (d_ready) begin
                got++;
                if (got == 1) k1 = k;
            end
        end
        d_req = 0;
        chk("b2b first", 64'(k1), 64'(LAT + 2));
        chk("b2b gap", 64'(k - k1), 64'(LAT + 3));
        @(posedge clk); #1;

        // Contention from a fresh reset so the round-robin history is known.
        rst_n = 0; #1; rst_n = 1;
        @(posedge clk); #1;
`ifdef MEM_ARB_RR_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h48;
        k = 0; got = 0;
        while (got < 4 && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (i_ready || d_ready) begin
                own[got] = d_ready;
                got++;
            end
        end
        d_req = 0;
        chk("contention count", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("contention owner%0d", i), {63'd0, own[i]}, {63'd0, exp_own[i]});
`ifndef MEM_ARB_RR_EN
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (i_ready) break;
        end
        chk("starved I latency", 64'(k), 64'(LAT + 3));
        rw = ref_rd(8'h40);
        chk("starved I rdata", {32'd0, i_rdata}, {32'd0, rw[63:32]});
`endif
        i_req = 0;
        @(posedge clk); #1;

        // Reset while a store to 16 is still counting down: no write, outputs cleared.
        d_req = 1; d_we = 1; d_addr = 32'd16; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0; d_req = 0; d_we = 0;
        #1;
        chk("midrst ctl", {61'd0, m_we, i_ready, d_ready}, 64'd0);
        chk("midrst m_addr", {32'd0, m_addr}, 64'd0);
        chk("midrst m_wdata", m_wdata, 64'd0);
        chk("midrst rdata", d_rdata | {32'd0, i_rdata}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        for (int j = 0; j < 8; j++)
            rw[63-8*j -: 8] = mem[16 + j];
        chk("midrst mem", rw, ref_rd(8'd16));
        @(posedge clk); #1;
        access(1, 0, 32'd16, 64'd0, ref_rd(8'd16), "post-reset load");

        // LATENCY=0 instance: load then a pending fetch served after one bubble.
        z_d_req = 1; z_d_addr = 32'h20; z_i_req = 1; z_i_addr = 32'd4;
        k = 0; k1 = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (z_d_ready && k1 == 0) begin
                k1 = k;
                chk("lat0 d_rdata", z_d_rdata, 64'h2122_2324_2526_2728);
                z_d_req = 0;
            end
            if (z_i_ready) break;
        end
        z_i_req = 0;
        chk("lat0 d latency", 64'(k1), 64'd2);
        chk("lat0 i latency", 64'(k), 64'd5);
        chk("lat0 i_rdata", {32'd0, z_i_rdata}, 64'h0000_0000_0506_0708);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
